// File: rtl/eth_udp_pkg.sv
// eth_udp_pkg: frame layout constants and FSM state type shared by the UDP frame builder
package eth_udp_pkg;
    localparam int ETH_HDR_LEN = 14;
    localparam int IP_HDR_LEN  = 20;
    localparam int UDP_HDR_LEN = 8;
    localparam int PAYLOAD_OFS = ETH_HDR_LEN + IP_HDR_LEN + UDP_HDR_LEN;
    localparam int MIN_FRAME   = 60;
    localparam int MIN_PAYLOAD = MIN_FRAME - PAYLOAD_OFS;
    localparam logic [15:0] ETHERTYPE_IPV4   = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP     = 8'h11;
    localparam logic [15:0] IPV4_VER_IHL_TOS = 16'h4500;
    typedef enum logic [1:0] {IDLE, CSUM, START, BUSY} state_t;
endpackage

// File: rtl/ipv4_csum.sv
// ipv4_csum: folds the ten IPv4 header words into a one's-complement checksum, one word per cycle
module ipv4_csum
    import eth_udp_pkg::*;
#(
    parameter logic [7:0]  TTL    = 8'd64,
    parameter logic [31:0] SRC_IP = 32'h0A000002,
    parameter logic [31:0] DST_IP = 32'h0A000001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_run,
    input  logic [15:0] i_total_len,
    input  logic [15:0] i_id,
    output logic [15:0] o_csum,
    output logic        o_done
);
    logic [3:0]   r_idx;
    logic [16:0]  r_acc;
    logic [15:0]  r_csum;
    logic [16:0]  w_sum;
    logic [159:0] w_words;
    logic [3:0]   w_sel;
    logic [15:0]  w_word;

    // checksum field itself is summed as zero
    assign w_words = {IPV4_VER_IHL_TOS, i_total_len, i_id, 16'h0000, TTL, IP_PROTO_UDP,
                      16'h0000, SRC_IP, DST_IP};
    assign w_sel   = 4'd9 - r_idx;
    assign w_word  = w_words[{w_sel, 4'b0000} +: 16];
    assign w_sum   = (r_idx == 4'd0 ? 17'd0 : {1'b0, r_acc[15:0]} + {16'd0, r_acc[16]}) + {1'b0, w_word};
    assign o_done  = i_run && r_idx == 4'd9;
    assign o_csum  = r_csum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx  <= 4'd0;
            r_acc  <= 17'd0;
            r_csum <= 16'd0;
        end else begin
            r_idx <= i_run ? r_idx + 4'd1 : 4'd0;
            if (i_run) r_acc <= w_sum;
            if (o_done) r_csum <= ~(w_sum[15:0] + {15'd0, w_sum[16]});
        end
    end
endmodule

// File: rtl/udp_frame_builder.sv
// udp_frame_builder: buffers a UDP payload and serves the full Ethernet/IPv4/UDP frame by address
module udp_frame_builder
    import eth_udp_pkg::*;
#(
    parameter int          MAX_PAYLOAD = 64,
    parameter logic [47:0] DST_MAC     = 48'hFFFFFFFFFFFF,
    parameter logic [47:0] SRC_MAC     = 48'h020000000002,
    parameter logic [31:0] SRC_IP      = 32'h0A000002,
    parameter logic [31:0] DST_IP      = 32'h0A000001,
    parameter logic [15:0] SRC_PORT    = 16'd1234,
    parameter logic [15:0] DST_PORT    = 16'd1234,
    parameter logic [7:0]  TTL         = 8'd64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic        start,
    output logic [10:0] frame_len,
    input  logic [10:0] rd_addr,
    output logic [7:0]  rd_data,
    input  logic        tx_done
);
    localparam int AW = MAX_PAYLOAD > 1 ? $clog2(MAX_PAYLOAD) : 1;

    state_t        r_state, w_next;
    logic [10:0]   r_plen;
    logic [15:0]   r_id;
    logic [7:0]    r_ram [MAX_PAYLOAD];
    logic [7:0]    r_rd_data;
    logic          w_accept, w_store, w_csum_done;
    logic [15:0]   w_csum, w_ip_len, w_udp_len;
    logic [335:0]  w_hdr;
    logic [5:0]    w_hsel;
    logic [AW-1:0] w_ofs;
    logic [7:0]    w_byte;

    assign in_ready  = r_state == IDLE && !rst;
    assign w_accept  = in_valid && in_ready;
    assign w_store   = w_accept && r_plen < 11'(MAX_PAYLOAD);
    assign start     = r_state == START;
    assign frame_len = 11'(PAYLOAD_OFS) + (r_plen > 11'(MIN_PAYLOAD) ? r_plen : 11'(MIN_PAYLOAD));
    assign w_ip_len  = 16'(IP_HDR_LEN + UDP_HDR_LEN) + {5'd0, r_plen};
    assign w_udp_len = 16'(UDP_HDR_LEN) + {5'd0, r_plen};
    assign rd_data   = r_rd_data;

    ipv4_csum #(.TTL(TTL), .SRC_IP(SRC_IP), .DST_IP(DST_IP)) u_csum (
        .clk         (clk),
        .rst         (rst),
        .i_run       (r_state == CSUM),
        .i_total_len (w_ip_len),
        .i_id        (r_id),
        .o_csum      (w_csum),
        .o_done      (w_csum_done)
    );

    always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_accept && in_last ? CSUM : IDLE;
            CSUM:    w_next = w_csum_done ? START : CSUM;
            START:   w_next = BUSY;
            BUSY:    w_next = tx_done ? IDLE : BUSY;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_plen <= 11'd0;
            r_id   <= 16'd0;
        end else if (r_state == BUSY && tx_done) begin
            r_plen <= 11'd0;
            r_id   <= r_id + 16'd1;
        end else if (w_store) begin
            r_plen <= r_plen + 11'd1;
        end
    end

    always_ff @(posedge clk) if (w_store) r_ram[r_plen[AW-1:0]] <= in_data;

    // header is a flat big-endian vector; byte 0 sits in the top eight bits
    assign w_hdr  = {DST_MAC, SRC_MAC, ETHERTYPE_IPV4, IPV4_VER_IHL_TOS, w_ip_len, r_id, 16'h0000,
                     TTL, IP_PROTO_UDP, w_csum, SRC_IP, DST_IP, SRC_PORT, DST_PORT, w_udp_len, 16'h0000};
    assign w_hsel = 6'd41 - rd_addr[5:0];
    assign w_ofs  = AW'(rd_addr - 11'(PAYLOAD_OFS));
    assign w_byte = rd_addr < 11'(PAYLOAD_OFS) ? w_hdr[{w_hsel, 3'b000} +: 8] :
                    rd_addr < 11'(PAYLOAD_OFS) + r_plen ? r_ram[w_ofs] : 8'h00;

    always_ff @(posedge clk) r_rd_data <= rst ? 8'h00 : w_byte;
endmodule

// File: tb/tb_udp_frame_builder.sv
// tb_udp_frame_builder: randomized scoreboard bench for udp_frame_builder against a frame-level model
`timescale 1ns/1ps
module tb_udp_frame_builder;
    localparam int          MAXP   = 64;
    localparam logic [47:0] DMAC   = 48'hFFFFFFFFFFFF;
    localparam logic [47:0] SMAC   = 48'h020000000002;
    localparam logic [31:0] SIP    = 32'h0A000002;
    localparam logic [31:0] DIP    = 32'h0A000001;
    localparam logic [15:0] SPORT  = 16'd1234;
    localparam logic [15:0] DPORT  = 16'd1234;
    localparam logic [7:0]  TTLV   = 8'd64;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0, rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0, in_last = 1'b0, tx_done = 1'b0;
    logic        in_ready, start;
    logic [10:0] frame_len;
    logic [10:0] rd_addr = 11'd0;
    logic [7:0]  rd_data;

    int          n_cmp = 0, n_fail = 0, ecnt = 0;
    logic        rd_en = 1'b0, rd_pend = 1'b0;
    int          exp_start_q[$], exp_len_q[$], exp_ra_q[$];
    logic [7:0]  exp_rd_q[$];
    logic [15:0] exp_id = 16'd0;

    udp_frame_builder #(.MAX_PAYLOAD(MAXP)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .start(start), .frame_len(frame_len), .rd_addr(rd_addr),
        .rd_data(rd_data), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ecnt    <= ecnt + 1;
        rd_pend <= rd_en;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // whole frame as the transmitter should see it, built from the field rules
    function automatic bq_t model_frame(input bq_t pl, input logic [15:0] id);
        bq_t f;
        logic [15:0] w[10];
        logic [31:0] s;
        int n;
        n = pl.size() > MAXP ? MAXP : pl.size();
        w = '{16'h4500, 16'(28 + n), id, 16'h0000, {TTLV, 8'h11}, 16'h0000,
              SIP[31:16], SIP[15:0], DIP[31:16], DIP[15:0]};
        s = 0;
        for (int i = 0; i < 10; i++) s += {16'd0, w[i]};
        s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        w[5] = ~s[15:0];
        for (int i = 5; i >= 0; i--) f.push_back(DMAC[8*i +: 8]);
        for (int i = 5; i >= 0; i--) f.push_back(SMAC[8*i +: 8]);
        f.push_back(8'h08); f.push_back(8'h00);
        for (int i = 0; i < 10; i++) begin f.push_back(w[i][15:8]); f.push_back(w[i][7:0]); end
        f.push_back(SPORT[15:8]); f.push_back(SPORT[7:0]);
        f.push_back(DPORT[15:8]); f.push_back(DPORT[7:0]);
        f.push_back(8'(( 8 + n) >> 8)); f.push_back(8'(8 + n));
        f.push_back(8'h00); f.push_back(8'h00);
        for (int i = 0; i < n; i++) f.push_back(pl[i]);
        while (f.size() < 60) f.push_back(8'h00);
        return f;
    endfunction

    function automatic bq_t seq_payload(input int n);
        bq_t p;
        for (int i = 0; i < n; i++) p.push_back(8'(i));
        return p;
    endfunction

    function automatic bq_t rand_payload(input int n);
        bq_t p;
        for (int i = 0; i < n; i++) p.push_back(8'($urandom));
        return p;
    endfunction

    task automatic send_payload(input bq_t pl, output int acc_edge);
        @(posedge clk); #1;
        for (int i = 0; i < pl.size(); i++) begin
            in_valid = 1'b1;
            in_data  = pl[i];
            in_last  = (i == pl.size() - 1);
            @(negedge clk);
            chk("in_ready_idle", in_ready, 1);
            @(posedge clk); #1;
        end
        acc_edge = ecnt;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_frame(input bq_t pl, input bit txd_csum, input bit hold_busy);
        bq_t f;
        int a, na;
        bit got;
        f = model_frame(pl, exp_id);
        send_payload(pl, a);
        exp_start_q.push_back(a + 10);
        exp_len_q.push_back(f.size());
        if (txd_csum) begin
            tx_done = 1'b1; @(posedge clk); #1; tx_done = 1'b0;
        end
        got = 1'b0;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            got = start;
        end
        if (!got) fail_now("start_timeout");
        if (hold_busy) begin
            in_valid = 1'b1; in_data = 8'hA5;
            repeat (3) begin @(negedge clk); chk("in_ready_busy", in_ready, 0); end
            in_valid = 1'b0;
        end
        na = f.size() + 4;
        for (int i = 0; i < na + 6; i++) begin
            int ad;
            ad = i < na ? i : int'($urandom_range(0, 2047));
            @(posedge clk); #1;
            rd_addr = 11'(ad);
            rd_en   = 1'b1;
            exp_ra_q.push_back(ad);
            exp_rd_q.push_back(ad < f.size() ? f[ad] : 8'h00);
        end
        @(posedge clk); #1;
        rd_en = 1'b0;
        chk("frame_len_busy", frame_len, f.size());
        tx_done = 1'b1; @(posedge clk); #1; tx_done = 1'b0;
        exp_id++;
        @(negedge clk);
        chk("in_ready_after_done", in_ready, 1);
    endtask

    always @(negedge clk) begin
        if (!rst && start) begin
            if (exp_start_q.size() == 0) fail_now("start_unexpected");
            else begin
                chk("start_cycle", ecnt, exp_start_q.pop_front());
                chk("frame_len", frame_len, exp_len_q.pop_front());
            end
        end
        if (rd_pend) begin
            if (exp_rd_q.size() == 0) fail_now("rd_unexpected");
            else chk($sformatf("rd_data[%0d]", exp_ra_q.pop_front()), rd_data, exp_rd_q.pop_front());
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("in_ready_in_reset", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_reset", in_ready, 1);
        chk("start_reset", start, 0);
        chk("rd_data_reset", rd_data, 0);
        chk("frame_len_reset", frame_len, 60);

        run_frame(seq_payload(18), 1'b1, 1'b1);
        run_frame(seq_payload(18), 1'b0, 1'b0);
        run_frame(rand_payload(5), 1'b0, 1'b0);
        run_frame(rand_payload(MAXP + 3), 1'b0, 1'b0);

        // reset in the middle of the checksum pass discards the frame
        send_payload(seq_payload(18), a);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("in_ready_rst_csum", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_id = 16'd0;
        @(negedge clk);
        chk("in_ready_post_rst", in_ready, 1);
        chk("start_post_rst", start, 0);
        chk("frame_len_post_rst", frame_len, 60);
        repeat (15) @(negedge clk);

        run_frame(seq_payload(18), 1'b0, 1'b0);
        for (int k = 0; k < 6; k++)
            run_frame(rand_payload(int'($urandom_range(1, MAXP + 3))), k[0], k == 2);

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", exp_start_q.size() + exp_rd_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
